imem_responder: RTL and testbench

- Instruction-memory responder; the memory-side end of the fetch interface.
- Fetch issues word-address requests over a valid/ready channel. This block returns the instruction word over a valid/ready response channel after a fixed pipeline latency.
- Supports multiple outstanding requests and response back-pressure, with an internal word array.
- A simple load port writes the array for program loading by the bench or boot logic.

---
 rtl/imem_responder.sv | 166 ++++++++++++++++
 tb/tb_imem_responder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts word-address fetch requests, reads an internal array and
// returns the words in order after a fixed latency, with response back-pressure and a load port.
module imem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_instr_o,
  output logic        resp_err_o,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DepthC     = CW'(DEPTH);
  localparam logic [PW-1:0] LastPtr    = PW'(DEPTH - 1);
  localparam logic [31:0]   MemWords32 = 32'(MEM_WORDS);
  localparam logic [31:0]   Nop        = 32'h0000_0013;

  logic [31:0] mem_q [MEM_WORDS];

  logic        accept;
  logic        pop;
  logic        req_err;
  logic [31:0] req_instr;
  logic        load_ok;

  logic        push_valid;
  logic [31:0] push_instr;
  logic        push_err;

  logic [31:0]   fifo_instr_q [DEPTH];
  logic [DEPTH-1:0] fifo_err_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [31:0]   last_instr_q;
  logic          last_err_q;

  assign req_ready_o = (out_cnt_q < DepthC);
  assign accept      = req_valid_i && req_ready_o;
  assign pop         = resp_valid_o && resp_ready_i;

  assign req_err   = (req_addr_i[1:0] != 2'b00) || ({2'b00, req_addr_i[31:2]} >= MemWords32);
  assign req_instr = req_err ? Nop : mem_q[req_addr_i[AW+1:2]];

  assign load_ok = load_en_i && (load_addr_i[1:0] == 2'b00) &&
                   ({2'b00, load_addr_i[31:2]} < MemWords32);

  // Array is never reset; the combinational read above sees the pre-edge contents (read-first).
  always_ff @(posedge clk_i) begin
    if (load_ok) begin
      mem_q[load_addr_i[AW+1:2]] <= load_data_i;
    end
  end

  // The FIFO push itself is the final latency stage, so only LATENCY-1 registers precede it.
  if (LATENCY == 1) begin : g_no_pipe
    assign push_valid = accept;
    assign push_instr = req_instr;
    assign push_err   = req_err;
  end else begin : g_pipe
    localparam int Stages = LATENCY - 1;

    logic [Stages-1:0] pipe_valid_q;
    logic [Stages-1:0] pipe_err_q;
    logic [31:0]       pipe_instr_q [Stages];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pipe_valid_q <= '0;
        pipe_err_q   <= '0;
        for (int i = 0; i < Stages; i++) begin
          pipe_instr_q[i] <= '0;
        end
      end else begin
        pipe_valid_q[0] <= accept;
        pipe_instr_q[0] <= req_instr;
        pipe_err_q[0]   <= req_err;
        for (int i = 1; i < Stages; i++) begin
          pipe_valid_q[i] <= pipe_valid_q[i-1];
          pipe_instr_q[i] <= pipe_instr_q[i-1];
          pipe_err_q[i]   <= pipe_err_q[i-1];
        end
      end
    end

    assign push_valid = pipe_valid_q[Stages-1];
    assign push_instr = pipe_instr_q[Stages-1];
    assign push_err   = pipe_err_q[Stages-1];
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    out_cnt_d  = out_cnt_q;
    if (push_valid) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_valid, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    case ({accept, pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      out_cnt_q    <= '0;
      last_instr_q <= '0;
      last_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_cnt_q  <= out_cnt_d;
      if (pop) begin
        last_instr_q <= fifo_instr_q[rd_ptr_q];
        last_err_q   <= fifo_err_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_valid) begin
      fifo_instr_q[wr_ptr_q] <= push_instr;
      fifo_err_q[wr_ptr_q]   <= push_err;
    end
  end

  // Outputs keep showing the last popped word once the FIFO drains.
  assign resp_valid_o = (fifo_cnt_q != '0);
  assign resp_instr_o = resp_valid_o ? fifo_instr_q[rd_ptr_q] : last_instr_q;
  assign resp_err_o   = resp_valid_o ? fifo_err_q[rd_ptr_q]   : last_err_q;

`ifndef SYNTHESIS
  a_fifo_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_valid && !pop && (fifo_cnt_q == DepthC)));
  a_outstanding_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    out_cnt_q <= DepthC);
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder with default parameters
// (MEM_WORDS=1024, LATENCY=2, DEPTH=4).
module tb_imem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic        resp_err;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int n_pass;
  int n_total;
  logic [31:0] prog [4];

  imem_responder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_instr_o (resp_instr),
    .resp_err_o   (resp_err),
    .load_en_i    (load_en),
    .load_addr_i  (load_addr),
    .load_data_i  (load_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    tick();
    tick();
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready);
    else n_pass++;
    n_total++;
    if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid);
    else n_pass++;
    n_total++;
    if (resp_instr !== 32'h0) $display("FAIL reset_resp_instr: got %h want 0", resp_instr);
    else n_pass++;
    n_total++;
    if (resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b want 0", resp_err);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    for (int i = 0; i < 4; i++) begin
      load_en   = 1'b1;
      load_addr = 32'(i * 4);
      load_data = prog[i];
      tick();
    end
    load_en    = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h0;
    tick();  // edge N
    req_valid = 1'b0;
    n_total++;
    if (resp_valid !== 1'b0) $display("FAIL single_not_early: got %b want 0", resp_valid);
    else n_pass++;
    tick();  // edge N+1
    n_total++;
    if (resp_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", resp_valid);
    else n_pass++;
    n_total++;
    if (resp_instr !== prog[0]) $display("FAIL single_instr: got %h want %h", resp_instr, prog[0]);
    else n_pass++;
    n_total++;
    if (resp_err !== 1'b0) $display("FAIL single_err: got %b want 0", resp_err);
    else n_pass++;
    tick();  // edge N+2 consumes it
    n_total++;
    if (resp_valid !== 1'b0) $display("FAIL single_consumed: got %b want 0", resp_valid);
    else n_pass++;
    n_total++;
    if (resp_instr !== prog[0]) $display("FAIL single_hold: got %h want %h", resp_instr, prog[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int got;
    int first;
    int last;
    got   = 0;
    first = -1;
    last  = -1;
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        req_valid = 1'b1;
        req_addr  = 32'(c * 4);
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL b2b_req_ready c%0d: got %b want 1", c, req_ready);
        else n_pass++;
      end else begin
        req_valid = 1'b0;
      end
      if (resp_valid === 1'b1) begin
        if (got < 4) begin
          n_total++;
          if (resp_instr !== prog[got])
            $display("FAIL b2b_instr %0d: got %h want %h", got, resp_instr, prog[got]);
          else n_pass++;
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      tick();
    end
    n_total++;
    if (got !== 4) $display("FAIL b2b_count: got %0d want 4", got);
    else n_pass++;
    n_total++;
    if (last - first !== 3) $display("FAIL b2b_consecutive: got span %0d want 3", last - first);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int accepts;
    int got;
    accepts    = 0;
    got        = 0;
    resp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1;
      req_addr  = (accepts < 4) ? 32'(accepts * 4) : 32'h0;
      if (req_ready === 1'b1) accepts++;
      tick();
    end
    n_total++;
    if (accepts !== 4) $display("FAIL bp_accepts: got %0d want 4", accepts);
    else n_pass++;
    n_total++;
    if (req_ready !== 1'b0) $display("FAIL bp_req_ready_low: got %b want 0", req_ready);
    else n_pass++;
    n_total++;
    if (resp_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", resp_valid);
    else n_pass++;
    n_total++;
    if (resp_instr !== prog[0]) $display("FAIL bp_head: got %h want %h", resp_instr, prog[0]);
    else n_pass++;
    tick();
    n_total++;
    if (resp_instr !== prog[0]) $display("FAIL bp_head_stable: got %h want %h", resp_instr, prog[0]);
    else n_pass++;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (resp_valid === 1'b1) begin
        if (got < 4) begin
          n_total++;
          if (resp_instr !== prog[got])
            $display("FAIL bp_drain_instr %0d: got %h want %h", got, resp_instr, prog[got]);
          else n_pass++;
        end
        got++;
      end
      tick();
      if (k == 0) begin
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL bp_ready_after_pop: got %b want 1", req_ready);
        else n_pass++;
      end
    end
    n_total++;
    if (got !== 4) $display("FAIL bp_drain_count: got %0d want 4", got);
    else n_pass++;
  endtask

  task automatic test_errors;
    int got;
    got        = 0;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h2;
    tick();
    req_addr = 32'h1000;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (resp_valid === 1'b1) begin
        n_total++;
        if (resp_instr !== 32'h0000_0013)
          $display("FAIL err_instr %0d: got %h want 00000013", got, resp_instr);
        else n_pass++;
        n_total++;
        if (resp_err !== 1'b1) $display("FAIL err_flag %0d: got %b want 1", got, resp_err);
        else n_pass++;
        got++;
      end
      tick();
    end
    n_total++;
    if (got !== 2) $display("FAIL err_count: got %0d want 2", got);
    else n_pass++;
  endtask

  task automatic test_load_collision;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h4;
    load_en    = 1'b1;
    load_addr  = 32'h4;
    load_data  = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0;
    load_en   = 1'b0;
    for (int k = 0; k < 6 && resp_valid !== 1'b1; k++) tick();
    n_total++;
    if (resp_valid !== 1'b1) $display("FAIL coll_old_timeout: got %b want 1", resp_valid);
    else n_pass++;
    n_total++;
    if (resp_instr !== 32'h0010_0113)
      $display("FAIL coll_old_value: got %h want 00100113", resp_instr);
    else n_pass++;
    n_total++;
    if (resp_err !== 1'b0) $display("FAIL coll_old_err: got %b want 0", resp_err);
    else n_pass++;
    tick();
    req_valid = 1'b1;
    req_addr  = 32'h4;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 6 && resp_valid !== 1'b1; k++) tick();
    n_total++;
    if (resp_valid !== 1'b1) $display("FAIL coll_new_timeout: got %b want 1", resp_valid);
    else n_pass++;
    n_total++;
    if (resp_instr !== 32'hDEAD_BEEF)
      $display("FAIL coll_new_value: got %h want deadbeef", resp_instr);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_midflight;
    int stale;
    stale      = 0;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(i * 4);
      tick();
    end
    req_valid = 1'b0;
    n_total++;
    if (resp_valid !== 1'b1) $display("FAIL midrst_precond: got %b want 1", resp_valid);
    else n_pass++;
    #3;
    rst = 1'b1;
    #1;
    n_total++;
    if (resp_valid !== 1'b0) $display("FAIL midrst_resp_valid: got %b want 0", resp_valid);
    else n_pass++;
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL midrst_req_ready: got %b want 1", req_ready);
    else n_pass++;
    n_total++;
    if (resp_instr !== 32'h0) $display("FAIL midrst_instr: got %h want 0", resp_instr);
    else n_pass++;
    #2;
    rst        = 1'b0;
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (resp_valid === 1'b1) stale++;
    end
    n_total++;
    if (stale !== 0) $display("FAIL midrst_stale: got %0d responses want 0", stale);
    else n_pass++;
    req_valid = 1'b1;
    req_addr  = 32'h8;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 6 && resp_valid !== 1'b1; k++) tick();
    n_total++;
    if (resp_valid !== 1'b1) $display("FAIL midrst_read_timeout: got %b want 1", resp_valid);
    else n_pass++;
    n_total++;
    if (resp_instr !== prog[2])
      $display("FAIL midrst_array_intact: got %h want %h", resp_instr, prog[2]);
    else n_pass++;
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_0073;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_load_collision();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
